// File: rtl/demux_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_queue_if
// Purpose  : Upstream push handshake plus head/pop bundle for demux_queue.
// Revision : 1.0  initial release
// ============================================================================
interface demux_queue_if #(
  parameter int ADDRESS_WIDTH = 2
);
  logic                            i_valid;
  logic                            o_ready;
  logic [ADDRESS_WIDTH-1:0]        i_address;
  logic                            i_x;
  logic                            o_valid;
  logic [ADDRESS_WIDTH-1:0]        o_address;
  logic                            o_x;
  logic [(1<<ADDRESS_WIDTH)-1:0]   i_dest_ready;
  logic                            o_pop;

  // Queue side.
  modport slave (
    input  i_valid, i_address, i_x, i_dest_ready,
    output o_ready, o_valid, o_address, o_x, o_pop
  );

  // Producer / demultiplexor side.
  modport master (
    output i_valid, i_address, i_x, i_dest_ready,
    input  o_ready, o_valid, o_address, o_x, o_pop
  );
endinterface
`default_nettype wire

// File: rtl/demux_queue.sv
`default_nettype none
// ============================================================================
// Module   : demux_queue
// Purpose  : FIFO feeder for a demultiplexor; retires the head only when its
//            addressed destination is ready. Optional occupancy output
//            o_level is enabled by defining DEMUX_QUEUE_LEVEL_EN.
// Revision : 1.0  initial release
// ============================================================================
module demux_queue #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DEPTH         = 4
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst,
  demux_queue_if.slave              bus
`ifdef DEMUX_QUEUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]    o_level
`endif
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = C_PTR_W + 1;
  localparam int C_ENTRY_W = ADDRESS_WIDTH + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  logic [C_ENTRY_W-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_CNT_W-1:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [C_ENTRY_W-1:0] w_head;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // Ready is held low during reset so nothing is offered into a clearing queue.
  assign bus.o_ready = ~i_rst & ~w_full;
  assign bus.o_valid = ~w_empty;

  // Head is masked to zero when empty so stale array contents never leak out.
  assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.o_address = w_head[C_ENTRY_W-1:1];
  assign bus.o_x       = w_head[0];

  assign w_push    = bus.i_valid & ~w_full;
  assign w_pop     = ~w_empty & bus.i_dest_ready[w_head[C_ENTRY_W-1:1]];
  assign bus.o_pop = w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible through the count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.i_address, bus.i_x};
    end
  end

`ifdef DEMUX_QUEUE_LEVEL_EN
  assign o_level = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_queue
// Purpose  : Self-checking bench for demux_queue against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux_queue;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int N     = 1 << AW;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  demux_queue_if #(.ADDRESS_WIDTH(AW)) bus ();

`ifdef DEMUX_QUEUE_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  demux_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef DEMUX_QUEUE_LEVEL_EN
    ,
    .o_level (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of {address, x} entries.
  logic [AW:0] q[$];
  bit          m_push;
  bit          m_pop;
  logic [AW:0] m_data;
  bit          last_acc;

  always @(negedge clk) begin
    bit          e_valid, e_ready, e_pop;
    logic [AW:0] e_head;
    if (rst) begin
      chk("rst_ready", bus.o_ready, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_pop", bus.o_pop, 0);
      m_push = 0;
      m_pop  = 0;
    end else begin
      e_valid = q.size() != 0;
      e_ready = q.size() < DEPTH;
      e_head  = e_valid ? q[0] : '0;
      e_pop   = e_valid && bus.i_dest_ready[e_head[AW:1]];
      chk("ready", bus.o_ready, e_ready);
      chk("valid", bus.o_valid, e_valid);
      chk("address", bus.o_address, e_head[AW:1]);
      chk("x", bus.o_x, e_head[0]);
      chk("pop", bus.o_pop, e_pop);
`ifdef DEMUX_QUEUE_LEVEL_EN
      chk("level", level, q.size());
`endif
      m_push = bus.i_valid && e_ready;
      m_pop  = e_pop;
      m_data = {bus.i_address, bus.i_x};
    end
  end

  always @(posedge clk) begin
    last_acc = m_push;
    if (rst) begin
      q.delete();
    end else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input bit v, input int a, input bit x);
    bus.i_valid   = v;
    bus.i_address = AW'(a);
    bus.i_x       = x;
  endtask

  task automatic drain();
    bus.i_valid      = 1'b0;
    bus.i_dest_ready = '1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.o_valid) break;
      tick();
    end
    chk("drain_empty", bus.o_valid, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    offer(0, 0, 0);
    bus.i_dest_ready = '0;
    @(negedge clk);
    chk("init_ready", bus.o_ready, 0);
    chk("init_valid", bus.o_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.o_ready, 1);
    tick();

    // Single entry held against a non-ready destination.
    offer(1, 2, 1);
    tick();
    offer(0, 0, 0);
    @(negedge clk);
    chk("t1_valid", bus.o_valid, 1);
    chk("t1_addr", bus.o_address, 2);
    chk("t1_x", bus.o_x, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t1_hold_pop", bus.o_pop, 0);
    end
    tick();
    bus.i_dest_ready = 4'b0100;
    @(negedge clk);
    chk("t1_pop", bus.o_pop, 1);
    tick();
    bus.i_dest_ready = '0;
    @(negedge clk);
    chk("t1_empty", bus.o_valid, 0);
    tick();

    // Fill to full, stall the fifth offer, free one slot.
    for (int i = 0; i < 4; i++) begin
      offer(1, i, i[0]);
      tick();
    end
    offer(1, 3, 1);
    @(negedge clk);
    chk("t2_full_ready", bus.o_ready, 0);
`ifdef DEMUX_QUEUE_LEVEL_EN
    chk("t2_level4", level, 4);
`endif
    tick();
    @(negedge clk);
    chk("t2_stall_ready", bus.o_ready, 0);
    tick();
    bus.i_dest_ready = 4'b0001;
    @(negedge clk);
    chk("t2_pop", bus.o_pop, 1);
    chk("t2_ready_reg", bus.o_ready, 0);
    tick();
    bus.i_dest_ready = '0;
    @(negedge clk);
    chk("t2_ready_back", bus.o_ready, 1);
    tick();
    offer(0, 0, 0);
    @(negedge clk);
    chk("t2_refull", bus.o_ready, 0);
    drain();

    // Streaming with all destinations ready.
    bus.i_dest_ready = '1;
    offer(1, 0, 1);
    @(negedge clk);
    chk("t3_first_pop", bus.o_pop, 0);
    tick();
    for (int i = 1; i < 10; i++) begin
      offer(1, i % 4, 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("t3_stream_pop", bus.o_pop, 1);
`ifdef DEMUX_QUEUE_LEVEL_EN
      chk("t3_level1", level, 1);
`endif
      tick();
    end
    offer(0, 0, 0);
    drain();

    // Head-of-line blocking.
    bus.i_dest_ready = 4'b1101;
    offer(1, 1, 1);
    tick();
    offer(1, 0, 0);
    tick();
    offer(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hol_pop", bus.o_pop, 0);
      chk("t4_hol_addr", bus.o_address, 1);
      tick();
    end
    bus.i_dest_ready = '1;
    @(negedge clk);
    chk("t4_first_addr", bus.o_address, 1);
    chk("t4_first_pop", bus.o_pop, 1);
    tick();
    @(negedge clk);
    chk("t4_second_addr", bus.o_address, 0);
    chk("t4_second_x", bus.o_x, 0);
    tick();
    @(negedge clk);
    chk("t4_empty", bus.o_valid, 0);
    tick();

    // Asynchronous reset mid-cycle with 3 entries queued.
    bus.i_dest_ready = '0;
    for (int i = 0; i < 3; i++) begin
      offer(1, i, 1);
      tick();
    end
    offer(0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_valid", bus.o_valid, 0);
`ifdef DEMUX_QUEUE_LEVEL_EN
    chk("t5_async_level", level, 0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready", bus.o_ready, 1);
    chk("t5_empty", bus.o_valid, 0);
    tick();

    // Sustained push+pop at count 2 across pointer wrap.
    offer(1, 1, 0);
    tick();
    offer(1, 2, 1);
    tick();
    bus.i_dest_ready = '1;
    for (int i = 0; i < 20; i++) begin
      offer(1, int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("t6_pop", bus.o_pop, 1);
`ifdef DEMUX_QUEUE_LEVEL_EN
      chk("t6_level2", level, 2);
`endif
      tick();
    end
    drain();

    // Randomized traffic with held offers and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (!(bus.i_valid && !last_acc)) begin
        offer($urandom_range(0, 3) != 0, int'($urandom_range(0, N - 1)),
              1'($urandom_range(0, 1)));
      end
      bus.i_dest_ready = N'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        offer(0, 0, 0);
      end
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_queue.md
# demux_queue

- Buffered, flow-controlled feeder that sits directly upstream of the `demultiplexor`.
- Accepts (address, data-bit) entries over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Presents the head entry on `o_address`/`o_x`, which connect straight to the demultiplexor's `i_address`/`i_x`.
- Retires the head only when the addressed destination signals ready, so each demux output sees one qualified strobe per entry.

## Interface

Parameters:
- `ADDRESS_WIDTH`, default 2: address width; number of destinations N = 1<<ADDRESS_WIDTH.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `i_clk`  input  1  sole clock; all state updates on the rising edge.
- `i_rst`  input  1  asynchronous, active-high reset.
- `i_valid`  input  1  upstream offers an entry.
- `o_ready`  output  1  queue can accept; equals !full.
- `i_address`  input  ADDRESS_WIDTH  destination of the offered entry.
- `i_x`  input  1  data bit of the offered entry.
- `o_valid`  output  1  queue non-empty; head entry presented.
- `o_address`  output  ADDRESS_WIDTH  head destination, to demultiplexor `i_address`.
- `o_x`  output  1  head data bit.
- `i_dest_ready`  input  N  per-destination ready, indexed by address.
- `o_pop`  output  1  head retired this cycle. Integrator drives demultiplexor `i_x` with `o_x & o_pop`.
- `o_level`  output  $clog2(DEPTH)+1  occupancy; present only with `DEMUX_QUEUE_LEVEL_EN`.

## Operation

- Storage: DEPTH × (ADDRESS_WIDTH+1) register array.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Count register, 0..DEPTH.
- Push:
  - push = i_valid & o_ready.
  - Writes {i_address, i_x} at the write pointer; write pointer increments.
- Pop:
  - pop = o_valid & i_dest_ready[o_address].
  - Read pointer increments.
  - o_pop = pop, combinational from registered state plus `i_dest_ready`.
- Count:
  - push only → +1.
  - pop only → −1.
  - push and pop together → unchanged; both pointers advance.
- Full (count == DEPTH):
  - o_ready = 0.
  - A pop in the same cycle does not enable a push; o_ready depends on registered count only.
- Empty (count == 0):
  - o_valid = 0, o_pop = 0.
  - o_address and o_x forced to 0.
  - No bypass: an entry pushed into an empty queue appears at the head the next cycle.
- Head-of-line blocking:
  - A non-ready destination stalls the whole queue.
  - Entries are never reordered or dropped.
- Handshake rules:
  - Upstream must hold i_address/i_x stable while i_valid=1 and o_ready=0.
  - o_valid never drops without a pop, except on reset.
- i_dest_ready bits for addresses other than o_address are ignored.
- Reset mid-operation:
  - All entries are discarded immediately; pointers and count clear asynchronously.
  - Array contents are not cleared; they are unobservable once empty.
  - Reset values: o_valid=0, o_pop=0, o_address=0, o_x=0, o_level=0.
  - o_ready is 0 while i_rst=1 and 1 from the first cycle after deassertion.

## Timing

- Latency:
  - Push in cycle t into an empty queue → o_valid=1 with that entry from cycle t+1.
  - Earliest pop is cycle t+1.
- Throughput: one push and one pop per cycle sustained while neither full nor empty.
- Combinational paths:
  - o_pop is combinational from i_dest_ready.
  - o_ready and o_valid are registered-state only; no path from i_valid or i_dest_ready.

## Configuration

- `DEMUX_QUEUE_LEVEL_EN` defined:
  - Port `o_level` exists and equals the count register.
  - Reset value 0; range 0..DEPTH.
- Not defined:
  - Port `o_level` is absent.
  - Behaviour is otherwise identical.

## Test plan

- Reset then single push {addr=2, x=1} with i_dest_ready=4'b0000 → o_valid=1, o_address=2, o_x=1 next cycle; held for 5 cycles with o_pop=0. Raise i_dest_ready[2] → o_pop=1 for one cycle, then o_valid=0.
- Push 4 entries (DEPTH=4) with all destinations not ready → o_ready=0 after the 4th push, o_level=4. Fifth offer stalls with i_valid held. One pop → o_ready=1 next cycle; fifth entry accepted.
- i_dest_ready=4'b1111, push every cycle for 10 cycles with addresses 0,1,2,3,0,… → o_pop high every cycle from cycle 1; o_level stays at 1; output order matches input order.
- Head addr=1 with i_dest_ready=4'b1101 → no pop (HOL blocking) despite second entry addr=0; set bit 1 → entries retire in order 1 then 0.
- Queue holding 3 entries, assert i_rst asynchronously mid-cycle → o_valid=0 and o_level=0 immediately; after release o_ready=1 and the queue is empty.
- Simultaneous push and pop at count=2 → count stays 2; wrap-around of both pointers past index 3 is verified by 20 sustained cycles with data integrity checked.
